// File: rtl/mem_line_responder.sv
// Memory-side responder for the L2 512-bit line interface: one outstanding
// line load/store, completed after a fixed latency from an on-chip line array.
module mem_line_responder #(
  parameter int          ADDR_W    = 64,
  parameter int          LG_LINES  = 12,
  parameter int          LATENCY   = 4,
  parameter logic [3:0]  OPC_LOAD  = 4'd0,
  parameter logic [3:0]  OPC_STORE = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_req_valid,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [511:0]      mem_req_store_data,
  input  logic [3:0]        mem_req_opcode,
  output logic              mem_req_ack,
  output logic              mem_rsp_valid,
  output logic [511:0]      mem_rsp_load_data,
  output logic              busy,
  output logic              bad_opcode,
  output logic [63:0]       load_count,
  output logic [63:0]       store_count
);

  localparam int         LINES    = 1 << LG_LINES;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RSP} state_t;

  state_t              state, next_state;
  logic [7:0]          cnt, next_cnt;
  logic [LG_LINES-1:0] idx_q;
  logic [3:0]          opc_q;
  logic [511:0]        data_q;
  logic [511:0]        mem [LINES];

  logic                accept;
  logic                enter_rsp;
  logic [LG_LINES-1:0] req_idx;
  logic [LG_LINES-1:0] rd_idx;
  logic [3:0]          rd_opc;
  logic                unused_addr_bits;

  // Offset bits and bits above the array size are dropped, so addresses alias.
  assign req_idx          = mem_req_addr[LG_LINES+5:6];
  assign unused_addr_bits = ^{mem_req_addr[ADDR_W-1:LG_LINES+6], mem_req_addr[5:0]};

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_valid) begin
          accept     = 1'b1;
          next_cnt   = CNT_INIT;
          next_state = (LATENCY == 1) ? RSP : WAIT;
        end
      end
      WAIT: begin
        if (cnt <= 8'd1) next_state = RSP;
        else             next_cnt   = cnt - 8'd1;
      end
      RSP:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    enter_rsp = (next_state == RSP);
    // With LATENCY==1 the read happens in the accept cycle, before latching.
    rd_idx    = accept ? req_idx        : idx_q;
    rd_opc    = accept ? mem_req_opcode : opc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      idx_q             <= '0;
      opc_q             <= '0;
      data_q            <= '0;
      mem_req_ack       <= 1'b0;
      mem_rsp_valid     <= 1'b0;
      mem_rsp_load_data <= '0;
      busy              <= 1'b0;
      bad_opcode        <= 1'b0;
      load_count        <= '0;
      store_count       <= '0;
    end else begin
      state         <= next_state;
      cnt           <= next_cnt;
      mem_req_ack   <= accept;
      mem_rsp_valid <= enter_rsp;
      busy          <= (next_state != IDLE);
      if (accept) begin
        idx_q  <= req_idx;
        opc_q  <= mem_req_opcode;
        data_q <= mem_req_store_data;
        if (mem_req_opcode != OPC_LOAD && mem_req_opcode != OPC_STORE)
          bad_opcode <= 1'b1;
      end
      // Unknown opcodes and stores respond with zero data.
      mem_rsp_load_data <= (enter_rsp && rd_opc == OPC_LOAD) ? mem[rd_idx] : '0;
      if (state == RSP) begin
        if (opc_q == OPC_LOAD)       load_count  <= load_count + 64'd1;
        else if (opc_q == OPC_STORE) store_count <= store_count + 64'd1;
      end
    end
  end

  // The array has no reset; a store caught by reset in its RSP cycle is dropped.
  always_ff @(posedge clk) begin
    if (!reset && state == RSP && opc_q == OPC_STORE)
      mem[idx_q] <= data_q;
  end

endmodule
